// File: rtl/xor_stream_descrambler.sv
// Descrambles a 16-bit word stream by XOR with a locally regenerated LFSR keystream.
// Single-entry output register with valid/ready handshakes on both sides.
module xor_stream_descrambler #(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   seed_load,
    input  logic [15:0]            seed,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic        accept;

    // Fibonacci LFSR step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] xor16(input logic [15:0] a, input logic [15:0] b);
        return a ^ b;
    endfunction

    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? DEFAULT_SEED : s;
    endfunction

    // A word may enter when the output slot is empty or drains this same cycle.
    assign in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == RUN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            lfsr       <= DEFAULT_SEED;
            out_valid  <= 1'b0;
            out_data   <= 16'h0000;
            word_count <= '0;
        end else if (seed_load) begin
            state      <= RUN;
            lfsr       <= seed_fix(seed);
            out_valid  <= 1'b0;
            word_count <= '0;
        end else if (accept) begin
            out_data   <= xor16(in_data, lfsr);
            out_valid  <= 1'b1;
            lfsr       <= lfsr_next(lfsr);
            word_count <= word_count + COUNT_WIDTH'(1);
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Randomized and directed bench for xor_stream_descrambler against a transaction-level model.
module tb_xor_stream_descrambler;

    logic        clk = 1'b0;
    logic        reset_n, seed_load, in_valid, out_ready;
    logic [15:0] seed, in_data;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_data, word_count;

    xor_stream_descrambler #(.DEFAULT_SEED(16'hACE1), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Model: keystream word n is the seed advanced n times; only counts matter.
    logic        m_run = 1'b0;
    logic        m_ov  = 1'b0;
    logic [15:0] m_od  = 16'h0000;
    logic [15:0] m_seed = 16'hACE1;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] keyword(input logic [15:0] s0, input int n);
        logic [15:0] s;
        s = s0;
        for (int i = 0; i < n; i++)
            s = (s << 1) | 16'(^(s & 16'hB400));
        return s;
    endfunction

    task automatic step(input logic rn, input logic sl, input logic [15:0] sd,
                        input logic iv, input logic [15:0] id, input logic ordy);
        logic rdy;
        reset_n = rn; seed_load = sl; seed = sd;
        in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        rdy = m_run && !sl && (!m_ov || ordy);
        if (rn) chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (!rn) begin
            m_run = 1'b0; m_ov = 1'b0; m_od = 16'h0000; m_cnt = 0;
        end else if (sl) begin
            m_run = 1'b1; m_seed = (sd == 16'h0000) ? 16'hACE1 : sd;
            m_ov = 1'b0; m_cnt = 0;
        end else if (iv && rdy) begin
            m_od = id ^ keyword(m_seed, m_cnt);
            m_ov = 1'b1;
            m_cnt++;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("word_count", word_count, m_cnt[15:0]);
        chk("busy", busy, m_run);
    endtask

    initial begin
        reset_n = 1'b0; seed_load = 1'b0; seed = 16'h0; in_valid = 1'b0;
        in_data = 16'h0; out_ready = 1'b0;
        @(posedge clk); #1;

        // reset and idle
        step(0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0, 16'h0, 0);
        step(1, 0, 16'h0, 1, 16'h1234, 1);
        chk("idle_ov", out_valid, 1'b0);
        chk("idle_cnt", word_count, 16'h0);
        chk("idle_busy", busy, 1'b0);

        // basic stream
        step(1, 1, 16'h0001, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1, 16'h1235, 1);
        chk("basic0", out_data, 16'h1234);
        step(1, 0, 16'h0, 1, 16'h567A, 1);
        chk("basic1", out_data, 16'h5678);
        chk("basic_cnt", word_count, 16'd2);

        // zero seed substitution
        step(1, 1, 16'h0000, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1, 16'h0000, 1);
        chk("zseed0", out_data, 16'hACE1);
        step(1, 0, 16'h0, 1, 16'h0000, 1);
        chk("zseed1", out_data, 16'h59C3);

        // backpressure
        step(1, 1, 16'h0001, 0, 16'h0, 1);
        step(1, 0, 16'h0, 1, 16'h1235, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0, 1, 16'h567A, 0);
            chk("bp_hold", out_data, 16'h1234);
            chk("bp_cnt", word_count, 16'd1);
        end
        step(1, 0, 16'h0, 1, 16'h567A, 1);
        chk("bp_next", out_data, 16'h5678);

        // reseed while a word is pending and input is offered
        step(1, 1, 16'h0001, 1, 16'hAAAA, 0);
        chk("reseed_ov", out_valid, 1'b0);
        chk("reseed_cnt", word_count, 16'h0);
        step(1, 0, 16'h0, 1, 16'h1235, 0);
        chk("reseed_key", out_data, 16'h1234);

        // reset while a word is pending
        step(0, 0, 16'h0, 1, 16'h1111, 0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_od", out_data, 16'h0);
        chk("rst_busy", busy, 1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic rn, sl, iv, ordy;
            logic [15:0] sd, id;
            rn   = ($urandom_range(99, 0) >= 1);
            sl   = ($urandom_range(99, 0) < 4);
            sd   = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
            iv   = ($urandom_range(99, 0) < 70);
            id   = 16'($urandom);
            ordy = ($urandom_range(99, 0) < 60);
            step(rn, sl, sd, iv, id, ordy);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
